// File: rtl/gate_product_accumulator.sv
// Accumulates the left-product of a chain of 2x2 complex gates using an external 2x2 multiplier.
// Optional macro GATE_ACC_BYPASS_FIRST_EN loads the first gate of a chain straight into the accumulator.
module gate_product_accumulator #(
    parameter int FRAC_BITS = 32,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [36:0] in_mtx [0:1][0:1][0:1],
    input  logic               in_last,
    output logic signed [36:0] mul_a [0:1][0:1][0:1],
    output logic signed [36:0] mul_b [0:1][0:1][0:1],
    output logic               mul_ready,
    input  logic               mul_completed,
    input  logic signed [36:0] mul_r [0:1][0:1][0:1],
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [36:0] out_mtx [0:1][0:1][0:1],
    output logic [CNT_W-1:0]   out_count
);
    localparam logic signed [36:0] ONE = 37'sd1 <<< FRAC_BITS;

    typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, WAIT_MUL, OUTPUT} state_t;

    state_t             state, state_next;
    logic signed [36:0] gate_q [0:1][0:1][0:1];
    logic signed [36:0] acc    [0:1][0:1][0:1];
    logic               last_q;
    logic [CNT_W-1:0]   count;
    logic               first_gate;

    assign first_gate = (count == '0);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mul_ready  = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: state_next = WAIT_IN;
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef GATE_ACC_BYPASS_FIRST_EN
                    if (first_gate) state_next = in_last ? OUTPUT : WAIT_IN;
                    else            state_next = ISSUE;
`else
                    state_next = ISSUE;
`endif
                end
            end
            ISSUE: begin
                mul_ready  = 1'b1;
                state_next = WAIT_MUL;
            end
            WAIT_MUL: begin
                if (mul_completed) state_next = last_q ? OUTPUT : WAIT_IN;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = WAIT_IN;
            end
            default: state_next = IDLE;
        endcase
        // Reset is synchronous, so the handshake outputs are masked combinationally while it is high.
        if (reset) begin
            in_ready  = 1'b0;
            mul_ready = 1'b0;
            out_valid = 1'b0;
        end
    end

    always_comb begin
        out_count = reset ? '0 : count;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < 2; p++) begin
                    mul_a[r][c][p]   = reset ? '0 : gate_q[r][c][p];
                    mul_b[r][c][p]   = reset ? '0 : acc[r][c][p];
                    out_mtx[r][c][p] = reset ? '0 : acc[r][c][p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last_q <= 1'b0;
            count  <= '0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int p = 0; p < 2; p++) begin
                        gate_q[r][c][p] <= '0;
                        acc[r][c][p]    <= (p == 0 && r == c) ? ONE : '0;
                    end
                end
            end
        end else begin
            state <= state_next;
            if (in_ready && in_valid) begin
                gate_q <= in_mtx;
                last_q <= in_last;
                if (count != '1) count <= count + CNT_W'(1);
`ifdef GATE_ACC_BYPASS_FIRST_EN
                if (first_gate) acc <= in_mtx;
`endif
            end
            if (state == WAIT_MUL && mul_completed) acc <= mul_r;
            // Product consumed: restart the next chain from identity.
            if (out_valid && out_ready) begin
                count <= '0;
                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 2; c++) begin
                        for (int p = 0; p < 2; p++) begin
                            acc[r][c][p] <= (p == 0 && r == c) ? ONE : '0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_product_accumulator.sv
// Scoreboard bench for gate_product_accumulator with a behavioural 2-cycle complex 2x2 multiplier.
module tb_gate_product_accumulator;
    localparam int FRAC = 32;
`ifdef GATE_ACC_BYPASS_FIRST_EN
    localparam int FIRST_PULSES = 0;
`else
    localparam int FIRST_PULSES = 1;
`endif

    typedef logic [7:0][36:0] flat_t;
    typedef struct {
        flat_t      mtx;
        logic [7:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic reset, in_valid, in_last, out_ready, stray_v;
    flat_t in_flat, stray_flat;
    flat_t mdl_r1 = '0, mdl_r2 = '0;
    logic  mdl_v1 = 1'b0, mdl_v2 = 1'b0;

    wire               in_ready, mul_ready, out_valid, mul_completed;
    wire [7:0]         out_count;
    wire signed [36:0] in_mtx  [0:1][0:1][0:1];
    wire signed [36:0] mul_a   [0:1][0:1][0:1];
    wire signed [36:0] mul_b   [0:1][0:1][0:1];
    wire signed [36:0] mul_r   [0:1][0:1][0:1];
    wire signed [36:0] out_mtx [0:1][0:1][0:1];
    wire [7:0][36:0]   out_flat, mula_flat, mulb_flat;

    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gate_product_accumulator #(.FRAC_BITS(FRAC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mtx(in_mtx), .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_completed(mul_completed), .mul_r(mul_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_mtx(out_mtx),
        .out_count(out_count)
    );

    for (genvar i = 0; i < 8; i++) begin : g_map
        assign in_mtx[i/4][(i/2)%2][i%2] = in_flat[i];
        assign out_flat[i]  = out_mtx[i/4][(i/2)%2][i%2];
        assign mula_flat[i] = mul_a[i/4][(i/2)%2][i%2];
        assign mulb_flat[i] = mul_b[i/4][(i/2)%2][i%2];
        assign mul_r[i/4][(i/2)%2][i%2] = stray_v ? stray_flat[i] : mdl_r2[i];
    end
    assign mul_completed = mdl_v2 | stray_v;

    function automatic logic signed [75:0] ent(input flat_t m, input int idx);
        logic signed [36:0] t;
        t = m[idx];
        return t;
    endfunction

    // Reference complex product a*b in Q(FRAC) fixed point.
    function automatic flat_t matmul(input flat_t a, input flat_t b);
        flat_t res;
        logic signed [75:0] re, im;
        res = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                re = '0;
                im = '0;
                for (int k = 0; k < 2; k++) begin
                    re = re + ent(a, r*4+k*2) * ent(b, k*4+c*2) - ent(a, r*4+k*2+1) * ent(b, k*4+c*2+1);
                    im = im + ent(a, r*4+k*2) * ent(b, k*4+c*2+1) + ent(a, r*4+k*2+1) * ent(b, k*4+c*2);
                end
                res[r*4+c*2]   = 37'(re >>> FRAC);
                res[r*4+c*2+1] = 37'(im >>> FRAC);
            end
        end
        return res;
    endfunction

    always @(posedge clk) begin
        mdl_v1 <= mul_ready;
        mdl_r1 <= matmul(mula_flat, mulb_flat);
        mdl_v2 <= mdl_v1;
        mdl_r2 <= mdl_r1;
    end

    always @(negedge clk) if (mul_ready === 1'b1) pulses++;

    task automatic compare(input string tag, input logic [295:0] obs, input logic [295:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        compare(tag, in_ready, 1'b1);
    endtask

    task automatic applyStimulus(input flat_t g, input logic last);
        waitReady("in_ready_wait");
        in_valid = 1'b1;
        in_flat  = g;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input int hold);
        int   n = 0;
        logic stable = 1'b1;
        exp_t e;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        compare("out_valid", out_valid, 1'b1);
        if (sb.size() == 0) begin
            fails++;
            $error("[TB] FAIL scoreboard: observed empty queue required an entry");
            return;
        end
        e = sb.pop_front();
        compare("out_mtx", out_flat, e.mtx);
        compare("out_count", out_count, e.count);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_flat !== e.mtx || in_ready !== 1'b0 || out_count !== e.count)
                stable = 1'b0;
        end
        if (hold > 0) compare("hold_stable", stable, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        compare("valid_drop", out_valid, 1'b0);
        compare("in_ready_after_out", in_ready, 1'b1);
    endtask

    initial begin
        flat_t ONE_F, X, S, ID, XS, SX;
        int    p0;
        logic  saw_valid;
        logic signed [36:0] one;
        one = 37'sd1 <<< FRAC;
        X  = '0; X[2] = one; X[4] = one;
        S  = '0; S[0] = one; S[7] = one;
        ID = '0; ID[0] = one; ID[6] = one;
        XS = '0; XS[3] = one; XS[4] = one;
        SX = '0; SX[2] = one; SX[5] = one;
        ONE_F = '0;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_flat = '0;
        out_ready = 1'b0; stray_v = 1'b0; stray_flat = '0;
        repeat (3) @(negedge clk);
        compare("rst_in_ready", in_ready, 1'b0);
        compare("rst_mul_ready", mul_ready, 1'b0);
        compare("rst_out_valid", out_valid, 1'b0);
        compare("rst_out_count", out_count, 8'd0);
        compare("rst_out_mtx", out_flat, ONE_F);
        compare("rst_mul_b", mulb_flat, ONE_F);
        reset = 1'b0;

        // Single gate X.
        p0 = pulses;
        sb.push_back('{X, 8'd1});
        applyStimulus(X, 1'b1);
        checkOutput(0);
        compare("t1_pulses", pulses - p0, FIRST_PULSES);

        // X then X gives identity.
        p0 = pulses;
        sb.push_back('{ID, 8'd2});
        applyStimulus(X, 1'b0);
        applyStimulus(X, 1'b1);
        checkOutput(0);
        compare("t2_pulses", pulses - p0, FIRST_PULSES + 1);

        // S then X gives X*S (left multiplication).
        sb.push_back('{XS, 8'd2});
        applyStimulus(S, 1'b0);
        applyStimulus(X, 1'b1);
        checkOutput(0);

        // Backpressure for 5 cycles, then a fresh chain.
        sb.push_back('{X, 8'd1});
        applyStimulus(X, 1'b1);
        checkOutput(5);
        sb.push_back('{S, 8'd1});
        applyStimulus(S, 1'b1);
        checkOutput(0);

        // Reset in WAIT_MUL, stray completions afterwards.
        applyStimulus(X, 1'b0);
        applyStimulus(X, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare("mid_rst_in_ready", in_ready, 1'b0);
        compare("mid_rst_mul_ready", mul_ready, 1'b0);
        compare("mid_rst_out_count", out_count, 8'd0);
        compare("mid_rst_mul_a", mula_flat, ONE_F);
        compare("mid_rst_out_mtx", out_flat, ONE_F);
        repeat (2) @(negedge clk);
        compare("mid_rst_out_valid", out_valid, 1'b0);
        reset = 1'b0;
        saw_valid = 1'b0;
        stray_flat = {8{37'h0_DEAD_BEEF}};
        stray_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) stray_v = 1'b0;
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        compare("post_rst_no_valid", saw_valid, 1'b0);
        sb.push_back('{S, 8'd1});
        applyStimulus(S, 1'b1);
        checkOutput(0);

        // Spurious completion while waiting for the second gate.
        sb.push_back('{SX, 8'd2});
        applyStimulus(X, 1'b0);
        waitReady("spur_wait");
        stray_v = 1'b1;
        repeat (2) @(negedge clk);
        stray_v = 1'b0;
        applyStimulus(S, 1'b1);
        checkOutput(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
